tp_input_conditioner: RTL

//  Sits between the raw touch-panel driver / board key and the top-level game FSM (menu/game/over + restart-region logic).

---
 rtl/tp_input_conditioner.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/tp_input_conditioner.sv
// Debounces the board key into a move_on pulse and turns raw touch samples into one tap per press.
// Latency: move_on 1 cycle after the debounced fall, tap 1 cycle after the confirming sample; no backpressure.
module tp_input_conditioner #(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter int          TOUCH_STABLE    = 3,
  parameter int          RELEASE_STABLE  = 3,
  parameter int          JITTER          = 8,
  parameter int          MAX_X           = 800,
  parameter int          MAX_Y           = 480,
  parameter logic [15:0] IDLE_COORD      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_n,
  input  logic        tp_sample_valid,
  input  logic        tp_pressed,
  input  logic [15:0] tp_raw_x,
  input  logic [15:0] tp_raw_y,
  output logic        move_on,
  output logic        tap_valid,
  output logic [15:0] tp_x_coord,
  output logic [15:0] tp_y_coord,
  output logic        touch_active
);

  localparam int KW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TOUCH_STABLE + 1);
  localparam int RW = $clog2(RELEASE_STABLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_HELD, S_RELEASE} state_t;

  logic          key_s1, key_s2, key_stable, key_stable_d;
  logic [KW-1:0] key_cnt;

  // With a 1-bit level, "synced differs from stable" only persists while the synced value is unchanged,
  // so returning to the stable level is the only way a run can break.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1       <= 1'b1;
      key_s2       <= 1'b1;
      key_stable   <= 1'b1;
      key_stable_d <= 1'b1;
      key_cnt      <= '0;
      move_on      <= 1'b0;
    end else begin
      key_s1       <= key_n;
      key_s2       <= key_s1;
      key_stable_d <= key_stable;
      move_on      <= key_stable_d & ~key_stable;
      if (key_s2 == key_stable) begin
        key_cnt <= '0;
      end else if (key_cnt == KW'(DEBOUNCE_CYCLES - 1)) begin
        key_stable <= key_s2;
        key_cnt    <= '0;
      end else begin
        key_cnt <= key_cnt + 1'b1;
      end
    end
  end

  state_t        state, state_n;
  logic [15:0]   anchor_x, anchor_y, anchor_x_n, anchor_y_n, fire_x, fire_y;
  logic [TW-1:0] cnt, cnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic          fire, sample_down, near;
  logic signed [16:0] dx, dy;
  logic [16:0]   dx_abs, dy_abs;

  assign sample_down = tp_pressed && (tp_raw_x < 16'(MAX_X)) && (tp_raw_y < 16'(MAX_Y));
  assign dx     = $signed({1'b0, tp_raw_x}) - $signed({1'b0, anchor_x});
  assign dy     = $signed({1'b0, tp_raw_y}) - $signed({1'b0, anchor_y});
  assign dx_abs = dx[16] ? 17'(-dx) : 17'(dx);
  assign dy_abs = dy[16] ? 17'(-dy) : 17'(dy);
  assign near   = (dx_abs <= 17'(JITTER)) && (dy_abs <= 17'(JITTER));
  assign touch_active = (state != S_IDLE);

  always_comb begin
    state_n    = state;
    anchor_x_n = anchor_x;
    anchor_y_n = anchor_y;
    cnt_n      = cnt;
    rcnt_n     = rcnt;
    fire       = 1'b0;
    fire_x     = anchor_x;
    fire_y     = anchor_y;
    if (tp_sample_valid) begin
      case (state)
        S_IDLE: begin
          if (sample_down) begin
            anchor_x_n = tp_raw_x;
            anchor_y_n = tp_raw_y;
            if (TOUCH_STABLE == 1) begin
              fire    = 1'b1;
              fire_x  = tp_raw_x;
              fire_y  = tp_raw_y;
              cnt_n   = '0;
              rcnt_n  = '0;
              state_n = S_HELD;
            end else begin
              cnt_n   = TW'(1);
              state_n = S_CONFIRM;
            end
          end
        end
        S_CONFIRM: begin
          if (!sample_down) begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end else if (near) begin
            if (cnt == TW'(TOUCH_STABLE - 1)) begin
              fire    = 1'b1;
              cnt_n   = '0;
              rcnt_n  = '0;
              state_n = S_HELD;
            end else if (cnt != TW'(TOUCH_STABLE)) begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            // finger slid too far: restart confirmation around the new position
            anchor_x_n = tp_raw_x;
            anchor_y_n = tp_raw_y;
            cnt_n      = TW'(1);
          end
        end
        S_HELD: begin
          if (!sample_down) begin
            if (RELEASE_STABLE == 1) begin
              rcnt_n  = '0;
              state_n = S_IDLE;
            end else begin
              rcnt_n  = RW'(1);
              state_n = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (sample_down) begin
            rcnt_n  = '0;
            state_n = S_HELD;
          end else if (rcnt == RW'(RELEASE_STABLE - 1)) begin
            rcnt_n  = '0;
            state_n = S_IDLE;
          end else if (rcnt != RW'(RELEASE_STABLE)) begin
            rcnt_n = rcnt + 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      anchor_x   <= '0;
      anchor_y   <= '0;
      cnt        <= '0;
      rcnt       <= '0;
      tap_valid  <= 1'b0;
      tp_x_coord <= IDLE_COORD;
      tp_y_coord <= IDLE_COORD;
    end else begin
      state      <= state_n;
      anchor_x   <= anchor_x_n;
      anchor_y   <= anchor_y_n;
      cnt        <= cnt_n;
      rcnt       <= rcnt_n;
      tap_valid  <= fire;
      tp_x_coord <= fire ? fire_x : IDLE_COORD;
      tp_y_coord <= fire ? fire_y : IDLE_COORD;
    end
  end

endmodule
